// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//
// Adds two (4*NIBBLES)-bit unsigned operands one nibble per clock, least
// significant nibble first, through a 4-bit carry look-ahead adder. The carry
// is registered between nibbles, so no carry path is wider than 4 bits.
// Handshake: start (in IDLE) -> busy for NIBBLES cycles -> done for one cycle.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset (priority over everything)
//   start  - add request, sampled only while idle
//   in1    - operand A (W bits), captured on the accepting edge
//   in2    - operand B (W bits), captured on the accepting edge
//   cin    - carry into nibble 0, captured on the accepting edge
//   busy   - high while nibbles are being added
//   done   - one-cycle pulse, sum/cout valid while high
//   sum    - registered W-bit result
//   cout   - registered carry-out of the top nibble

module carry_look_adder (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] carry;

  // Every carry is a flat sum of generate/propagate terms, so no carry
  // ripples through the sum logic of a lower bit.
  always_comb begin
    gen      = in1 & in2;
    prop     = in1 ^ in2;
    carry[0] = cin;
    carry[1] = gen[0] | (prop[0] & cin);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cin);
    cout     = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
    sum      = prop ^ carry;
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in1,
  input  logic [4*NIBBLES-1:0] in2,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  // {idx, 2'b00} is the bit offset 4*idx of the current nibble.
  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];

  carry_look_adder u_cla (
    .in1  (nib_a),
    .in2  (nib_b),
    .cin  (c_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // busy/done are decoded from the next state and registered so that both
  // outputs come straight from flops and line up with the state register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          c_d     = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
        c_d = nib_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//
// Scoreboard bench for nibble_serial_adder (NIBBLES=4). Stimulus pushes the
// arithmetic result {cout, sum} = in1 + in2 + cin into a queue when an add is
// accepted; an independent monitor pops and compares on every done pulse and
// also watches busy/done exclusivity and result stability while idle.

module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  logic [W:0] expQ[$];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison; prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned addition of the operands.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Wait through the busy phase (optionally scrambling operands), then check
  // that busy lasted exactly N cycles and done follows immediately.
  task automatic waitDone(input bit scramble);
    int busyCycles;
    busyCycles = 0;
    while (busy && busyCycles < 20) begin
      busyCycles++;
      if (scramble) begin
        in1 = W'($urandom);
        in2 = W'($urandom);
        cin = 1'($urandom);
      end
      tick();
    end
    checkOutput("busy_len", busyCycles, N);
    checkOutput("done_after_busy", {31'd0, done}, 1);
  endtask

  // Issue one add with a one-cycle start pulse, run it to completion and
  // leave the DUT back in IDLE.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input bit scramble);
    in1   = a;
    in2   = b;
    cin   = c;
    start = 1'b1;
    expQ.push_back(model(a, b, c));
    tick();
    start = 1'b0;
    checkOutput("busy_on_accept", {31'd0, busy}, 1);
    waitDone(scramble);
    tick();
  endtask

  // Monitor: compares results on done and checks handshake invariants.
  initial begin : monitor
    logic       rstAtEdge;
    logic       holdValid;
    logic [W:0] lastVal;
    logic [W:0] expVal;
    holdValid = 1'b0;
    lastVal   = '0;
    forever begin
      @(posedge clk);
      rstAtEdge = rst;
      #2;
      checkOutput("busy_done_exclusive", {31'd0, busy & done}, 0);
      if (done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got {cout,sum}=0x%0h expected no done at %0t",
                   {cout, sum}, $time);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("result", {15'd0, cout, sum}, {15'd0, expVal});
        end
        lastVal   = {cout, sum};
        holdValid = 1'b1;
      end else if (busy || rstAtEdge) begin
        holdValid = 1'b0;
      end else if (holdValid) begin
        checkOutput("result_hold", {15'd0, cout, sum}, {15'd0, lastVal});
      end
    end
  end

  // Main stimulus sequence.
  initial begin : stim
    int dc0;
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    cin   = 1'b0;

    // Reset held for two edges, then released with start low.
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_sum", {16'd0, sum}, 0);
    checkOutput("rst_cout", {31'd0, cout}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_state", {14'd0, busy, done, cout, sum}, 0);
    end

    // Basic add and full carry ripple cases.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);

    // start held high: second op accepted one edge after done falls.
    in1   = 16'h00FF;
    in2   = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    expQ.push_back(model(16'h00FF, 16'h0001, 1'b0));
    tick();
    checkOutput("held_accept", {31'd0, busy}, 1);
    waitDone(1'b0);
    in1 = 16'h1111;
    in2 = 16'h2222;
    cin = 1'b1;
    expQ.push_back(model(16'h1111, 16'h2222, 1'b1));
    tick();
    checkOutput("no_accept_in_done", {31'd0, busy}, 0);
    tick();
    checkOutput("accept_after_done", {31'd0, busy}, 1);
    start = 1'b0;
    waitDone(1'b1);
    tick();

    // A start pulse during RUN is dropped: exactly one done results.
    dc0   = doneCount;
    in1   = 16'h0A0A;
    in2   = 16'h0505;
    cin   = 1'b0;
    start = 1'b1;
    expQ.push_back(model(16'h0A0A, 16'h0505, 1'b0));
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N + 4; i++) tick();
    checkOutput("single_done", doneCount - dc0, 1);

    // Reset on the second RUN edge aborts the add.
    dc0   = doneCount;
    in1   = 16'hABCD;
    in2   = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_sum", {16'd0, sum}, 0);
    checkOutput("abort_cout", {31'd0, cout}, 0);
    for (int i = 0; i < N + 3; i++) tick();
    checkOutput("abort_no_done", doneCount - dc0, 0);
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 1'b0);

    // Random regression with operand scrambling during RUN and idle gaps.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    for (int i = 0; i < 4; i++) tick();
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
